// File: rtl/gf180mcu_osu_sc_gp9t3v3__clkdiv_pkg.sv
// Shared types and helpers for the glitch-free programmable clock divider.
// Ratio encoding: N = DIV + 2, high phase H = ceil(N/2).
package gf180mcu_osu_sc_gp9t3v3__clkdiv_pkg;

    localparam int DEFAULT_W         = 5;
    localparam int DEFAULT_RESET_DIV = 0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // ceil((div_code + 2) / 2); odd ratios get the longer high phase
    function automatic logic [31:0] high_cycles(input logic [31:0] div_code);
        return (div_code + 32'd3) >> 1;
    endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_gp9t3v3__clkdiv_if.sv
// Control/status bundle between the divider and its controller.
interface gf180mcu_osu_sc_gp9t3v3__clkdiv_if
    import gf180mcu_osu_sc_gp9t3v3__clkdiv_pkg::*;
#(
    parameter int W = DEFAULT_W
) ();

    logic         en;
    logic         load;
    logic [W-1:0] div;
    logic         ack;
    logic         busy;
    logic         y;

    modport master (
        output en,
        output load,
        output div,
        input  ack,
        input  busy,
        input  y
    );

    modport slave (
        input  en,
        input  load,
        input  div,
        output ack,
        output busy,
        output y
    );

endinterface

// File: rtl/gf180mcu_osu_sc_gp9t3v3__clkdiv_ctr.sv
// Period counter and registered Y generator for the active ratio.
// The period restarts or stops only at the boundary count N-1.
module gf180mcu_osu_sc_gp9t3v3__clkdiv_ctr
    import gf180mcu_osu_sc_gp9t3v3__clkdiv_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] act_div,
    input  logic         running,
    input  logic         restart,
    output logic         boundary,
    output logic         y
);

    localparam int CW = W + 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          y_q;
    logic          y_d;
    logic [CW-1:0] last_cnt;
    logic [CW-1:0] high;
    logic [CW-1:0] cnt_inc;

    // N-1 = DIV+1, kept in W+1 bits so N = 2^W+1 never wraps
    assign last_cnt = CW'(act_div) + CW'(1);
    assign high     = CW'(high_cycles(32'(act_div)));
    assign cnt_inc  = cnt_q + CW'(1);
    assign boundary = running && (cnt_q == last_cnt);

    always_comb begin
        cnt_d = '0;
        y_d   = 1'b0;
        if (running && !boundary) begin
            cnt_d = cnt_inc;
            y_d   = (cnt_inc < high);
        end else begin
            // idle or boundary: either open a fresh period high or park low
            cnt_d = '0;
            y_d   = restart;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            y_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            y_q   <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/gf180mcu_osu_sc_gp9t3v3__clkdiv.sv
// Glitch-free integer clock divider: run/stop FSM plus LOAD/ACK ratio handshake.
// New ratios and EN take effect only in IDLE or on a whole-period boundary.
module gf180mcu_osu_sc_gp9t3v3__clkdiv
    import gf180mcu_osu_sc_gp9t3v3__clkdiv_pkg::*;
#(
    parameter int W         = DEFAULT_W,
    parameter int RESET_DIV = DEFAULT_RESET_DIV
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    gf180mcu_osu_sc_gp9t3v3__clkdiv_if.slave        bus
);

    state_e       state_q;
    state_e       state_d;
    logic [W-1:0] act_q;
    logic [W-1:0] act_d;
    logic [W-1:0] pend_q;
    logic [W-1:0] pend_d;
    logic         pend_v_q;
    logic         pend_v_d;
    logic         ack_q;
    logic         ack_d;
    logic         apply;
    logic         boundary;
    logic         running;
    logic         y_int;

    assign running = (state_q == RUN);

    always_comb begin
        state_d  = state_q;
        act_d    = act_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        ack_d    = 1'b0;
        apply    = 1'b0;

        case (state_q)
            IDLE: begin
                apply = 1'b1;
                if (bus.en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (boundary) begin
                    apply = 1'b1;
                    if (!bus.en) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase

        if (apply) begin
            // a same-cycle LOAD supersedes whatever is pending
            if (bus.load) begin
                act_d = bus.div;
                ack_d = 1'b1;
            end else if (pend_v_q) begin
                act_d = pend_q;
                ack_d = 1'b1;
            end
            pend_v_d = 1'b0;
        end else if (bus.load) begin
            pend_d   = bus.div;
            pend_v_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            act_q    <= W'(RESET_DIV);
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            act_q    <= act_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            ack_q    <= ack_d;
        end
    end

    gf180mcu_osu_sc_gp9t3v3__clkdiv_ctr #(
        .W (W)
    ) u_ctr (
        .clk      (CLK),
        .rst      (RST),
        .act_div  (act_q),
        .running  (running),
        .restart  (bus.en),
        .boundary (boundary),
        .y        (y_int)
    );

    assign bus.y    = y_int;
    assign bus.ack  = ack_q;
    assign bus.busy = pend_v_q;

endmodule
